// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding unit: operand-select codes,
// FSM state encoding and default register-address width.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 4;
  localparam int unsigned FWD_W          = 2;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } hz_state_e;

  // EXE producer is newer than MEM, so it wins when both match
  function automatic logic [FWD_W-1:0] fwd_code(input logic ex_hit, input logic mem_hit);
    if (ex_hit) begin
      return FWD_MEM;
    end
    if (mem_hit) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_dep_compare.sv
// Single-operand dependency comparator: flags a match of one ID-stage source
// against the EXE- and MEM-stage destinations.
module dep_compare
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  src_valid,
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic                  exe_wb_en,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  output logic                  ex_hit,
  output logic                  mem_hit
);

  assign ex_hit  = src_valid & exe_wb_en & (src_addr == exe_dest);
  assign mem_hit = src_valid & mem_wb_en & (src_addr == mem_dest);

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: load-use stall FSM, registered forwarding selects and
// saturating stall statistics. Define FORWARDING_EN for forwarding; otherwise
// the legacy interlock stalls on any EXE/MEM dependency.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W        = REG_ADDR_W_DEF,
  parameter int unsigned NUM_SRC           = 2,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned STAT_W            = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic                          exe_wb_en,
  input  logic                          exe_mem_read,
  input  logic [REG_ADDR_W-1:0]         exe_dest,
  input  logic                          mem_wb_en,
  input  logic [REG_ADDR_W-1:0]         mem_dest,
  input  logic                          mem_ready,
  output logic                          hazard_detected,
  output logic                          freeze,
  output logic [NUM_SRC*FWD_W-1:0]      fwd_sel,
  output logic [STAT_W-1:0]             stall_count
);

  localparam int unsigned CNT_W = $clog2(LOAD_STALL_CYCLES + 1);

  logic [NUM_SRC-1:0]       ex_hit;
  logic [NUM_SRC-1:0]       mem_hit;
  logic                     lu;
  logic                     hazard_c;

  hz_state_e                state_q;
  hz_state_e                state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  logic [NUM_SRC*FWD_W-1:0] fwd_q;
  logic [NUM_SRC*FWD_W-1:0] fwd_d;
  logic [STAT_W-1:0]        stall_q;
  logic [STAT_W-1:0]        stall_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_cmp
    dep_compare #(
      .REG_ADDR_W(REG_ADDR_W)
    ) u_cmp (
      .src_valid (src_valid[i]),
      .src_addr  (src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
      .exe_wb_en (exe_wb_en),
      .exe_dest  (exe_dest),
      .mem_wb_en (mem_wb_en),
      .mem_dest  (mem_dest),
      .ex_hit    (ex_hit[i]),
      .mem_hit   (mem_hit[i])
    );
  end

  assign lu     = exe_mem_read & (|ex_hit);
  assign freeze = ~mem_ready;

`ifndef FORWARDING_EN
  // Load-use detection is not consulted by the legacy interlock
  logic legacy_unused;
  assign legacy_unused = lu;
`endif

  // Stall FSM: a frozen pipeline holds state and suppresses the stall
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hazard_c = 1'b0;
    if (!freeze) begin
      unique case (state_q)
        IDLE: begin
`ifdef FORWARDING_EN
          if (lu) begin
            hazard_c = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = LOAD_WAIT;
              cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 1);
            end
          end
`else
          hazard_c = |(ex_hit | mem_hit);
`endif
        end
        LOAD_WAIT: begin
          hazard_c = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Operand selects for the instruction entering EXE next cycle
  always_comb begin
    fwd_d = fwd_q;
    if (!freeze) begin
`ifdef FORWARDING_EN
      if (hazard_c) begin
        fwd_d = '0;
      end else begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          fwd_d[i*FWD_W +: FWD_W] = fwd_code(ex_hit[i], mem_hit[i]);
        end
      end
`else
      fwd_d = '0;
`endif
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hazard_c && (stall_q != {STAT_W{1'b1}})) begin
      stall_d = stall_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fwd_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fwd_q   <= fwd_d;
      stall_q <= stall_d;
    end
  end

  // Reset must drop the stall at once, even with a load-use pair still present
  assign hazard_detected = hazard_c & ~rst;
  assign fwd_sel         = fwd_q;
  assign stall_count     = stall_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized self-checking bench for hazard_forward_unit against a cycle-level
// reference model; follows the FORWARDING_EN setting of the build.
module tb_hazard_forward_unit;

  localparam int unsigned AW  = 4;
  localparam int unsigned NS  = 2;
  localparam int unsigned LSC = 3;
  localparam int unsigned SW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    src_valid;
  logic [NS*AW-1:0] src_addr;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [AW-1:0]    exe_dest;
  logic             mem_wb_en;
  logic [AW-1:0]    mem_dest;
  logic             mem_ready;
  logic             hazard_detected;
  logic             freeze;
  logic [NS*2-1:0]  fwd_sel;
  logic [SW-1:0]    stall_count;

  int errors = 0;
  int checks = 0;

  // Reference state: extra stall cycles still owed, expected selects, stall count
  int            rem   = 0;
  logic [NS*2-1:0] m_fwd = '0;
  int            m_cnt = 0;

  hazard_forward_unit #(
    .REG_ADDR_W        (AW),
    .NUM_SRC           (NS),
    .LOAD_STALL_CYCLES (LSC),
    .STAT_W            (SW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .src_valid       (src_valid),
    .src_addr        (src_addr),
    .exe_wb_en       (exe_wb_en),
    .exe_mem_read    (exe_mem_read),
    .exe_dest        (exe_dest),
    .mem_wb_en       (mem_wb_en),
    .mem_dest        (mem_dest),
    .mem_ready       (mem_ready),
    .hazard_detected (hazard_detected),
    .freeze          (freeze),
    .fwd_sel         (fwd_sel),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    src_valid    = '0;
    src_addr     = '0;
    exe_wb_en    = 1'b0;
    exe_mem_read = 1'b0;
    exe_dest     = '0;
    mem_wb_en    = 1'b0;
    mem_dest     = '0;
  endtask

  // Called at a falling edge with inputs set: check outputs, then advance one cycle
  task automatic step();
    logic [NS-1:0] eh;
    logic [NS-1:0] mh;
    logic          lu_m;
    logic          hz;
    logic          frz;
    #1;
    if (rst) begin
      rem   = 0;
      m_fwd = '0;
      m_cnt = 0;
    end
    frz = !mem_ready;
    for (int i = 0; i < NS; i++) begin
      eh[i] = src_valid[i] && exe_wb_en && (src_addr[i*AW +: AW] == exe_dest);
      mh[i] = src_valid[i] && mem_wb_en && (src_addr[i*AW +: AW] == mem_dest);
    end
    lu_m = exe_mem_read && (eh != '0);
`ifdef FORWARDING_EN
    hz = !rst && !frz && ((rem > 0) || lu_m);
`else
    hz = !rst && !frz && ((eh | mh) != '0);
`endif
    check_val("hazard_detected", 32'(hazard_detected), 32'(hz));
    check_val("freeze", 32'(freeze), 32'(frz));
    check_val("fwd_sel", 32'(fwd_sel), 32'(m_fwd));
    check_val("stall_count", 32'(stall_count), 32'(m_cnt));
    @(posedge clk);
    if (!rst && !frz) begin
      if (hz && m_cnt < (1 << SW) - 1) m_cnt++;
`ifdef FORWARDING_EN
      if (rem > 0) rem--;
      else if (lu_m) rem = LSC - 1;
      for (int i = 0; i < NS; i++) begin
        if (hz)         m_fwd[2*i +: 2] = 2'd0;
        else if (eh[i]) m_fwd[2*i +: 2] = 2'd1;
        else if (mh[i]) m_fwd[2*i +: 2] = 2'd2;
        else            m_fwd[2*i +: 2] = 2'd0;
      end
`endif
    end
    @(negedge clk);
  endtask

  task automatic set_load_use(input logic [AW-1:0] r);
    clear_inputs();
    src_valid[0]    = 1'b1;
    src_addr[0 +: AW] = r;
    exe_wb_en       = 1'b1;
    exe_mem_read    = 1'b1;
    exe_dest        = r;
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b1;
    clear_inputs();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    repeat (3) step();

    // ALU result in EXE feeding src0
    src_valid[0] = 1'b1; src_addr[0 +: AW] = 4'd3; exe_wb_en = 1'b1; exe_dest = 4'd3;
    step();
    clear_inputs();
    step();
    step();

    // src1 matches both EXE and MEM
    src_valid[1] = 1'b1; src_addr[AW +: AW] = 4'd5;
    exe_wb_en = 1'b1; exe_dest = 4'd5; mem_wb_en = 1'b1; mem_dest = 4'd5;
    step();
    clear_inputs();
    step();

    // Load-use stall held over the programmed length
    set_load_use(4'd7);
    repeat (LSC) step();
    clear_inputs();
    repeat (2) step();

    // Same stall with a two-cycle freeze inside it
    set_load_use(4'd7);
    step();
    step();
    mem_ready = 1'b0;
    repeat (2) step();
    mem_ready = 1'b1;
    step();
    clear_inputs();
    repeat (2) step();

    // Reset in the middle of the stall
    set_load_use(4'd7);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    repeat (2) step();

    // Random traffic over a small register range to provoke frequent matches
    for (int n = 0; n < 3000; n++) begin
      src_valid    = NS'($urandom);
      for (int i = 0; i < NS; i++) src_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
      exe_wb_en    = 1'($urandom);
      exe_mem_read = ($urandom_range(0, 2) == 0);
      exe_dest     = AW'($urandom_range(0, 3));
      mem_wb_en    = 1'($urandom);
      mem_dest     = AW'($urandom_range(0, 3));
      mem_ready    = ($urandom_range(0, 9) != 0);
      rst          = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    mem_ready = 1'b1;
    clear_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
